// File: rtl/wide_prefetch.sv
// wide_prefetch: bus-width instruction prefetcher with a byte queue.
// Optional PREFETCH_BYPASS_EN presents the first byte in the ack cycle.
module wide_prefetch #(
  parameter int BUS_BYTES = 2,
  parameter int DEPTH     = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [15:0]                       cs,
  input  logic [15:0]                       new_ip,
  input  logic                              load_new_ip,
  output logic                              q_valid,
  output logic [7:0]                        q_data,
  output logic [15:0]                       q_ip,
  input  logic                              q_rd_en,
  output logic [$clog2(DEPTH+1)-1:0]        q_count,
  output logic                              mem_access,
  input  logic                              mem_ack,
  output logic [19-$clog2(BUS_BYTES):0]     mem_address,
  input  logic [8*BUS_BYTES-1:0]            mem_data
);

  localparam int OFS = $clog2(BUS_BYTES);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int FW  = CW + 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int NW  = OFS + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ABORT
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       fetch_ip_q, fetch_ip_d;
  logic [19-OFS:0]   addr_q, addr_d;
  logic [OFS-1:0]    off_q, off_d;
  logic [NW-1:0]     n_q, n_d;
  logic [15:0]       qip_q, qip_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW-1:0]     wr_q, wr_d;
  logic [7:0]        fifo [DEPTH];

  logic [19:0]          phys;
  logic [OFS-1:0]       off_new;
  logic [NW-1:0]        room;
  logic [16:0]          tail;
  logic [NW-1:0]        n_new;
  logic [FW-1:0]        free;
  logic                 launch;
  logic                 ack_ok;
  logic                 byp;
  logic                 pop;
  logic                 qpop;
  logic                 byp_pop;
  logic [NW-1:0]        wr_n;
  logic [8*BUS_BYTES-1:0] head;
  logic [8*BUS_BYTES-1:0] wdata;

  // Launch address and byte count for the next fetch.
  assign phys    = {cs, 4'b0000} + {4'b0000, fetch_ip_q};
  assign off_new = phys[OFS-1:0];
  assign room    = NW'(BUS_BYTES) - {1'b0, off_new};
  assign tail    = 17'h10000 - {1'b0, fetch_ip_q};
  assign n_new   = (tail < {{(17-NW){1'b0}}, room}) ? NW'(tail) : room;

  assign ack_ok  = (state_q == REQ) && mem_ack && !load_new_ip;

`ifdef PREFETCH_BYPASS_EN
  assign byp = ack_ok && (cnt_q == '0);
`else
  assign byp = 1'b0;
`endif

  // Word bytes from the fetch offset onward, one more skipped if bypassed.
  assign head    = mem_data >> {off_q, 3'b000};
  assign pop     = q_rd_en && q_valid && !load_new_ip;
  assign qpop    = pop && !byp;
  assign byp_pop = pop && byp;
  assign wdata   = byp_pop ? (head >> 8) : head;
  assign wr_n    = ack_ok ? (n_q - NW'(byp_pop)) : '0;

  assign free    = FW'(DEPTH) - {1'b0, cnt_q} + FW'(pop);
  assign launch  = !load_new_ip && (free >= FW'(BUS_BYTES));

  assign q_valid     = (cnt_q != '0) || byp;
  assign q_data      = byp ? head[7:0] : fifo[rd_q];
  assign q_ip        = qip_q;
  assign q_count     = cnt_q;
  assign mem_access  = (state_q != IDLE);
  assign mem_address = addr_q;

  // Fetch FSM: launch, wait for ack, or drain an aborted request.
  always_comb begin
    state_d    = state_q;
    fetch_ip_d = fetch_ip_q;
    addr_d     = addr_q;
    off_d      = off_q;
    n_d        = n_q;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = REQ;
          addr_d  = phys[19:OFS];
          off_d   = off_new;
          n_d     = n_new;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = IDLE;
        end else if (load_new_ip) begin
          state_d = ABORT;
        end
        if (ack_ok) begin
          fetch_ip_d = fetch_ip_q + 16'(n_q);
        end
      end
      ABORT: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_new_ip) begin
      fetch_ip_d = new_ip;
    end
  end

  // Queue pointers, occupancy and head IP.
  always_comb begin
    cnt_d = cnt_q - CW'(qpop) + CW'(wr_n);
    rd_d  = rd_q + AW'(qpop);
    wr_d  = wr_q + AW'(wr_n);
    qip_d = qip_q + 16'(pop);
    if (load_new_ip) begin
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
      qip_d = new_ip;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_ip_q <= '0;
      addr_q     <= '0;
      off_q      <= '0;
      n_q        <= '0;
      qip_q      <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetch_ip_q <= fetch_ip_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      n_q        <= n_d;
      qip_q      <= qip_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  // Byte storage: write the accepted bytes in order at the tail.
  always_ff @(posedge clk) begin
    for (int j = 0; j < BUS_BYTES; j++) begin
      if (NW'(j) < wr_n) begin
        fifo[wr_q + AW'(j)] <= wdata[8*j +: 8];
      end
    end
  end

endmodule

// File: doc/wide_prefetch.md
# wide_prefetch

Parametrised instruction prefetcher with an internal byte queue. Fetches code words of configurable bus width from CS:IP, unpacks only the bytes at or beyond the current IP into a local FIFO, and presents one byte per cycle to the decoder with the IP of that byte. It sits between the CPU memory arbiter and the instruction decoder. It flushes cleanly on a branch, including when a bus request is outstanding.

## Interface
Parameters:
- BUS_BYTES, 2: bytes per memory word. Legal values are 2 and 4. OFS = log2(BUS_BYTES).
- DEPTH, 8: queue depth in bytes. Power of two, at least 2*BUS_BYTES.

Ports:
- clk  in  1  clock. The block has one clock.
- reset  in  1  synchronous, active-high reset.
- cs  in  16  code segment. Sampled when a request is launched.
- new_ip  in  16  branch target IP.
- load_new_ip  in  1  flushes the queue and redirects fetch to cs:new_ip.
- q_valid  out  1  head byte is valid.
- q_data  out  8  head byte.
- q_ip  out  16  IP of the head byte.
- q_rd_en  in  1  pops the head byte. Ignored when q_valid=0.
- q_count  out  $clog2(DEPTH+1)  bytes held in the queue.
- mem_access  out  1  bus request.
- mem_ack  in  1  one-cycle pulse; mem_data is valid in that cycle.
- mem_address  out  20-OFS  word address, bits [19:OFS].
- mem_data  in  8*BUS_BYTES  read word; byte k is at bits [8k+7:8k].

## Operation
- Physical address: phys = ({cs,4'b0} + {4'b0,fetch_ip}) mod 2^20. mem_address = phys[19:OFS]. off = phys[OFS-1:0].
- Bytes taken per ack: n = min(BUS_BYTES-off, 65536-fetch_ip).
  - The queue stores word bytes off..off+n-1, in order.
  - fetch_ip then advances by n, mod 2^16.
  - When a segment wraps at 0xFFFF, the next fetch starts at cs:0000.
- State machine:
  - IDLE
    - Go to REQ when !load_new_ip and free space (DEPTH-q_count) >= BUS_BYTES, with the pop in the same cycle counted.
    - Latch mem_address and n on that transition.
  - REQ
    - mem_access=1 and mem_address is held.
    - mem_ack without load_new_ip: write n bytes to the queue, advance fetch_ip, go to IDLE.
    - mem_ack with load_new_ip: discard the data, go to IDLE.
    - load_new_ip without ack: go to ABORT.
  - ABORT
    - mem_access stays 1 and mem_address keeps the old address. A request is never withdrawn.
    - On mem_ack the data is discarded and the state goes to IDLE.
- load_new_ip, in any state:
  - queue emptied: q_count=0 and q_valid=0 next cycle;
  - fetch_ip and q_ip both take new_ip;
  - a same-cycle pop and a same-cycle queue write are both suppressed.
  - A repeated load_new_ip while in ABORT only retargets fetch_ip.
- Pop: q_rd_en && q_valid removes the head byte and increments q_ip (mod 2^16). A pop and a write in the same cycle are both performed; q_count changes by n-1.
- Queue overflow cannot occur. The space check is made before the request is launched.
- Reset values: state IDLE, q_valid 0, q_count 0, q_ip 0, fetch_ip 0, mem_access 0, mem_address 0. The first fetch after reset is cs:0000.

## Timing
- mem_access is registered from state. It is low in the cycle after an ack, so there is at least one IDLE cycle between requests.
- Load-to-request latency: load_new_ip at cycle t (state IDLE) gives mem_access=1 at t+2.
- Ack-to-data latency, without bypass: ack at t gives q_valid=1 at t+1.
- q_data and q_ip are stable while q_valid=1 and no pop occurs.
- mem_address is stable from request launch until the ack.

## Configuration
- PREFETCH_BYPASS_EN.
- Defined: when the queue is empty, an accepted ack (REQ, no load_new_ip) drives q_valid=1 and q_data=mem_data byte off combinationally in the ack cycle.
  - A q_rd_en in that cycle consumes the byte; the remaining n-1 bytes are queued.
  - If it is not popped, all n bytes are queued.
- Undefined: q_valid is registered only. The first byte appears one cycle after the ack.

## Test plan
- Reset with cs=0xF000, BUS_BYTES=2 -> first request mem_address = 0xF0000>>1 = 0x78000. Ack with mem_data=0x1234 -> q_data sequence 0x34 then 0x12, with q_ip 0x0000 then 0x0001.
- BUS_BYTES=4, load_new_ip new_ip=0x0003, cs=0 -> one byte (byte 3) queued, then the next fetch at word address 1 with 4 bytes queued. q_ip runs 3,4,5,6,7.
- Segment wrap: new_ip=0xFFFF, cs=0x1000, BUS_BYTES=2 -> one byte taken from phys 0x1FFFF, then the next request is at phys 0x10000. q_ip goes 0xFFFF then 0x0000.
- load_new_ip while in REQ, with the ack delayed 3 cycles -> mem_access held with the old address. The ack data is not queued. The next request targets the new IP. q_valid stays 0 throughout.
- No pops with DEPTH=8, BUS_BYTES=2 -> exactly 4 acks, then q_count=8 and mem_access stays 0. One pop -> still no request, since free space 1 < 2. A second pop -> a request launches.
- With PREFETCH_BYPASS_EN, empty queue, ack with q_rd_en=1 -> q_valid=1 in the ack cycle and q_count=1 in the next cycle. Without the macro -> q_valid=0 in the ack cycle.
